display_arbiter: RTL

- Arbitrates the shared 7-segment display between the player's information sources: elapsed time, volume, track number and paused status.
- Volume and track changes raise timed overlays. Track has priority over volume.
- A lower-priority overlay that is blocked is queued, not lost.
- When no overlay is active, the display falls back to time, or to a blinking paused indicator while playback is paused.
- Sits between the control FSM (request pulses) and the display mux/decoder (select and blank).

---
 rtl/display_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - selects what the shared 7-segment display shows: time, volume, track or paused blink.
module display_arbiter #(
  parameter int CLOCK_FREQ   = 100,
  parameter int HOLD_SECONDS = 5,
  parameter int HOLD_CYCLES  = CLOCK_FREQ * HOLD_SECONDS,
  parameter int BLINK_CYCLES = CLOCK_FREQ / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_volume,
  input  logic       req_track,
  input  logic       paused,
  input  logic       force_time,
  output logic [1:0] display_select,
  output logic       blank,
  output logic       overlay_active
);

  localparam logic [1:0] ST_TIME   = 2'd0;
  localparam logic [1:0] ST_VOLUME = 2'd1;
  localparam logic [1:0] ST_TRACK  = 2'd2;
  localparam logic [1:0] ST_PAUSE  = 2'd3;

  localparam logic [27:0] HOLD_LAST  = 28'(HOLD_CYCLES - 1);
  localparam logic [27:0] BLINK_LAST = 28'(BLINK_CYCLES - 1);

  logic [1:0]  state, state_n;
  logic [27:0] hold_cnt, hold_n;
  logic [27:0] blink_cnt, blink_n;
  logic        pending_vol, pend_n;
  logic        blank_n;
  logic        overlay_q;
  logic [1:0]  base;
  logic        in_overlay;
  logic        hold_done;
  logic        pend_eff;

  always_comb begin
    base       = paused ? ST_PAUSE : ST_TIME;
    in_overlay = (state == ST_VOLUME) || (state == ST_TRACK);
    hold_done  = (hold_cnt == HOLD_LAST);
    pend_eff   = pending_vol | req_volume;
    state_n    = state;
    hold_n     = hold_cnt;
    pend_n     = pending_vol;

    if (req_track) begin
      state_n = ST_TRACK;
      hold_n  = '0;
      pend_n  = pend_eff;
    end else if (req_volume && state != ST_TRACK) begin
      state_n = ST_VOLUME;
      hold_n  = '0;
    end else if (force_time && !req_volume && in_overlay) begin
      state_n = base;
      hold_n  = '0;
      pend_n  = 1'b0;
    end else begin
      case (state)
        ST_VOLUME: begin
          if (hold_done) begin
            state_n = base;
            hold_n  = '0;
          end else begin
            hold_n = hold_cnt + 28'd1;
          end
        end
        // A volume request queued behind track still lets track run its full window.
        ST_TRACK: begin
          if (hold_done) begin
            state_n = pend_eff ? ST_VOLUME : base;
            hold_n  = '0;
            pend_n  = 1'b0;
          end else begin
            hold_n = hold_cnt + 28'd1;
            pend_n = pend_eff;
          end
        end
        default: state_n = base;
      endcase
    end
  end

  always_comb begin
    blink_n = '0;
    blank_n = 1'b0;
    if (state_n == ST_PAUSE && state == ST_PAUSE) begin
      if (blink_cnt == BLINK_LAST) begin
        blank_n = ~blank;
      end else begin
        blink_n = blink_cnt + 28'd1;
        blank_n = blank;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_TIME;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
      pending_vol <= 1'b0;
      blank       <= 1'b0;
      overlay_q   <= 1'b0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_n;
      blink_cnt   <= blink_n;
      pending_vol <= pend_n;
      blank       <= blank_n;
      overlay_q   <= (state_n == ST_VOLUME) || (state_n == ST_TRACK);
    end
  end

  assign display_select = state;
  assign overlay_active = overlay_q;

endmodule
